// File: rtl/periph_port_scheduler.sv
// Shares one peripheral slave port between NB_REQ requesters.
//
// Round-robin arbitration on the request channel, an in-order FIFO of one-hot
// requester IDs to route responses back, and a watchdog that turns a silent
// slave into an error response so no requester hangs forever.
//
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   req_i/add_i/wdata_i/wen_i per-requester request channel (packed, req 0 in LSBs)
//   gnt_o                     per-requester grant (one-hot or zero)
//   r_valid_o                 per-requester response valid (one-hot or zero)
//   r_rdata_o, r_opc_o        shared response data / error flag
//   m_req_o .. m_id_o         request channel towards the peripheral
//   m_gnt_i                   peripheral grant
//   m_r_valid_i/_rdata_i/_opc_i  peripheral response channel
//   timeout_o                 one-cycle pulse when the head transaction is aborted
//   outstanding_o             issued-but-unanswered transactions (incl. stale ones)
module periph_port_scheduler #(
  parameter int unsigned           NB_REQ          = 9,
  parameter int unsigned           ADDR_WIDTH      = 32,
  parameter int unsigned           DATA_WIDTH      = 32,
  parameter int unsigned           MAX_OUTSTANDING = 2,
  parameter int unsigned           TIMEOUT_CYCLES  = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA       = 32'hBADACCE5
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NB_REQ-1:0]                      req_i,
  input  logic [NB_REQ*ADDR_WIDTH-1:0]           add_i,
  input  logic [NB_REQ*DATA_WIDTH-1:0]           wdata_i,
  input  logic [NB_REQ-1:0]                      wen_i,
  output logic [NB_REQ-1:0]                      gnt_o,
  output logic [NB_REQ-1:0]                      r_valid_o,
  output logic [DATA_WIDTH-1:0]                  r_rdata_o,
  output logic                                   r_opc_o,
  output logic                                   m_req_o,
  input  logic                                   m_gnt_i,
  output logic [ADDR_WIDTH-1:0]                  m_add_o,
  output logic [DATA_WIDTH-1:0]                  m_wdata_o,
  output logic                                   m_wen_o,
  output logic [NB_REQ-1:0]                      m_id_o,
  input  logic                                   m_r_valid_i,
  input  logic [DATA_WIDTH-1:0]                  m_r_rdata_i,
  input  logic                                   m_r_opc_i,
  output logic                                   timeout_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned RW = $clog2(NB_REQ);
  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CW:0]   OCC_MAX  = (CW+1)'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);
  localparam logic [RW-1:0] RR_LAST  = RW'(NB_REQ - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);

  logic [RW-1:0]     rr_q;
  logic [NB_REQ-1:0] fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]     fifo_cnt_q;
  logic [CW-1:0]     stale_q;   // aborted transactions whose late response is still due
  logic [WW-1:0]     wd_q;

  // Occupancy and full flag come from registered state only, so a pop never
  // unblocks a push in the same cycle.
  logic [CW:0] occ;
  logic        full;
  assign occ           = {1'b0, fifo_cnt_q} + {1'b0, stale_q};
  assign full          = (occ == OCC_MAX);
  assign outstanding_o = occ[CW-1:0];

  // Round-robin search starting at rr_q, wrapping around.
  logic          win_found;
  logic [RW-1:0] win_idx;
  logic [RW-1:0] cand;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NB_REQ; i++) begin
      cand = RW'((32'(rr_q) + i) % NB_REQ);
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  logic push;
  assign m_req_o = win_found & ~full;
  assign push    = m_req_o & m_gnt_i;

  always_comb begin
    m_add_o   = '0;
    m_wdata_o = '0;
    m_wen_o   = 1'b0;
    m_id_o    = '0;
    gnt_o     = '0;
    if (m_req_o) begin
      m_add_o          = add_i[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
      m_wdata_o        = wdata_i[win_idx*DATA_WIDTH +: DATA_WIDTH];
      m_wen_o          = wen_i[win_idx];
      m_id_o[win_idx]  = 1'b1;
      gnt_o[win_idx]   = m_gnt_i;
    end
  end

  // Response path. A stale response is absorbed before any FIFO entry is
  // touched, since in-order slaves answer the aborted transaction first.
  logic              fifo_empty;
  logic              stale_nz;
  logic              resp_pop;
  logic              resp_drop;
  logic              wd_hit;
  logic              pop;
  logic [NB_REQ-1:0] head;

  assign fifo_empty = (fifo_cnt_q == '0);
  assign stale_nz   = (stale_q != '0);
  assign head       = fifo_q[rd_ptr_q];
  assign resp_pop   = m_r_valid_i & ~stale_nz & ~fifo_empty;
  assign resp_drop  = m_r_valid_i & stale_nz;
  // A real response in the watchdog's final cycle wins over the abort.
  assign wd_hit     = ~fifo_empty & ~resp_pop & (wd_q == WD_LAST);
  assign pop        = resp_pop | wd_hit;
  assign timeout_o  = wd_hit;

  always_comb begin
    r_valid_o = '0;
    r_rdata_o = '0;
    r_opc_o   = 1'b0;
    if (resp_pop) begin
      r_valid_o = head;
      r_rdata_o = m_r_rdata_i;
      r_opc_o   = m_r_opc_i;
    end else if (wd_hit) begin
      r_valid_o = head;
      r_rdata_o = ERR_RDATA;
      r_opc_o   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q       <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      stale_q    <= '0;
      wd_q       <= '0;
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= m_id_o;
        wr_ptr_q         <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        rr_q             <= (win_idx == RR_LAST) ? '0 : win_idx + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      end

      unique case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase

      unique case ({wd_hit, resp_drop})
        2'b10:   stale_q <= stale_q + 1'b1;
        2'b01:   stale_q <= stale_q - 1'b1;
        default: stale_q <= stale_q;
      endcase

      if (fifo_empty || pop) begin
        wd_q <= '0;
      end else begin
        wd_q <= wd_q + 1'b1;
      end
    end
  end

  // A response with nothing outstanding breaks the slave protocol.
  assert property (@(posedge clk_i) disable iff (rst_i) !(m_r_valid_i && (occ == '0)));

  assert property (@(posedge clk_i) disable iff (rst_i) (occ <= OCC_MAX));

endmodule
